div: RTL and testbench

//   Multi-cycle 32-bit integer divider for DIV/DIVU; feeds the EX stage.
//   EX latches operands and holds start_i; the block iterates one quotient bit per cycle.
//   It returns {remainder, quotient} with ready_o. EX writes result_o[63:32] to HI and

---
 rtl/div_if.sv | 22 ++
 rtl/div.sv | 154 +++++++++++++++
 tb/tb_div.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/div_if.sv
// Handshake bundle between the EX stage and the multi-cycle divider.
interface div_if #(
  parameter int WIDTH = 32
);
  logic                   signed_div_i;
  logic [WIDTH-1:0]       opdata1_i;
  logic [WIDTH-1:0]       opdata2_i;
  logic                   start_i;
  logic                   annul_i;
  logic [2*WIDTH-1:0]     result_o;
  logic                   ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div.sv
// Restoring divider for DIV/DIVU: one quotient bit per cycle, result {remainder, quotient}.
module div #(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst,
  div_if.slave  bus
);

  localparam int            CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_LAST  = CW'(WIDTH);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t               state_r;
  logic [CW-1:0]        cnt_r;
  logic [2*WIDTH:0]     dividend_r;
  logic [WIDTH-1:0]     divisor_r;
  logic                 signed_r;
  logic                 op1_sign_r;
  logic                 op2_sign_r;
  logic [2*WIDTH-1:0]   result_r;
  logic                 ready_r;

  logic [WIDTH-1:0]     op1_abs_s;
  logic [WIDTH-1:0]     op2_abs_s;
  logic [WIDTH:0]       diff_s;
  logic [2*WIDTH:0]     step_s;
  logic [WIDTH-1:0]     quo_s;
  logic [WIDTH-1:0]     rem_s;

  function automatic logic [WIDTH-1:0] neg2c(input logic [WIDTH-1:0] x);
    return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Operand magnitudes, restoring step and sign-corrected final result.
  always_comb begin
    op1_abs_s = bus.opdata1_i;
    op2_abs_s = bus.opdata2_i;
    if (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) begin
      op1_abs_s = neg2c(bus.opdata1_i);
    end else begin
      op1_abs_s = bus.opdata1_i;
    end
    if (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) begin
      op2_abs_s = neg2c(bus.opdata2_i);
    end else begin
      op2_abs_s = bus.opdata2_i;
    end

    diff_s = {1'b0, dividend_r[2*WIDTH-1:WIDTH]} - {1'b0, divisor_r};
    step_s = dividend_r << 1;
    if (diff_s[WIDTH]) begin
      step_s = dividend_r << 1;
    end else begin
      step_s = {diff_s[WIDTH-1:0], dividend_r[WIDTH-1:0], 1'b1};
    end

    // The remainder follows the dividend's sign, the quotient the XOR of both signs.
    quo_s = dividend_r[WIDTH-1:0];
    rem_s = dividend_r[2*WIDTH:WIDTH+1];
    if (signed_r && (op1_sign_r ^ op2_sign_r)) begin
      quo_s = neg2c(dividend_r[WIDTH-1:0]);
    end else begin
      quo_s = dividend_r[WIDTH-1:0];
    end
    if (signed_r && op1_sign_r) begin
      rem_s = neg2c(dividend_r[2*WIDTH:WIDTH+1]);
    end else begin
      rem_s = dividend_r[2*WIDTH:WIDTH+1];
    end
  end

  // Control FSM with registered result and ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= S_FREE;
      cnt_r      <= CNT_ZERO;
      dividend_r <= {(2*WIDTH+1){1'b0}};
      divisor_r  <= {WIDTH{1'b0}};
      signed_r   <= 1'b0;
      op1_sign_r <= 1'b0;
      op2_sign_r <= 1'b0;
      result_r   <= {(2*WIDTH){1'b0}};
      ready_r    <= 1'b0;
    end else begin
      case (state_r)
        S_FREE: begin
          ready_r  <= 1'b0;
          result_r <= {(2*WIDTH){1'b0}};
          if (bus.start_i && !bus.annul_i) begin
            signed_r   <= bus.signed_div_i;
            op1_sign_r <= bus.opdata1_i[WIDTH-1];
            op2_sign_r <= bus.opdata2_i[WIDTH-1];
            dividend_r <= {{WIDTH{1'b0}}, op1_abs_s, 1'b0};
            divisor_r  <= op2_abs_s;
            cnt_r      <= CNT_ZERO;
            if (bus.opdata2_i == {WIDTH{1'b0}}) begin
              state_r <= S_BYZERO;
            end else begin
              state_r <= S_ON;
            end
          end else begin
            state_r <= S_FREE;
          end
        end
        S_BYZERO: begin
          state_r  <= S_END;
          ready_r  <= 1'b1;
          result_r <= {(2*WIDTH){1'b0}};
        end
        S_ON: begin
          if (bus.annul_i) begin
            state_r  <= S_FREE;
            ready_r  <= 1'b0;
            result_r <= {(2*WIDTH){1'b0}};
          end else if (cnt_r != CNT_LAST) begin
            dividend_r <= step_s;
            cnt_r      <= cnt_r + CNT_ONE;
          end else begin
            state_r  <= S_END;
            ready_r  <= 1'b1;
            result_r <= {rem_s, quo_s};
          end
        end
        S_END: begin
          if (bus.start_i) begin
            state_r <= S_END;
          end else begin
            state_r  <= S_FREE;
            ready_r  <= 1'b0;
            result_r <= {(2*WIDTH){1'b0}};
          end
        end
        default: begin
          state_r  <= S_FREE;
          ready_r  <= 1'b0;
          result_r <= {(2*WIDTH){1'b0}};
        end
      endcase
    end
  end

  assign bus.result_o = result_r;
  assign bus.ready_o  = ready_r;

endmodule

// File: tb/tb_div.sv
// Randomized and directed checks of div against a plain-arithmetic reference model.
module tb_div;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  div_if #(.WIDTH(32)) bus ();

  div #(.WIDTH(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Reference: 64-bit host arithmetic truncates toward zero, remainder takes the dividend sign.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic wait_ready(input int budget, output int lat);
    int i;
    lat = 0;
    i = 0;
    while (lat == 0 && i < budget) begin
      i++;
      @(posedge clk);
      @(negedge clk);
      if (bus.ready_o) lat = i;
    end
  endtask

  // One full transaction: accept, scramble operands, check latency, hold, release.
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] got);
    logic [63:0] exp;
    int          lat;
    int          exp_lat;
    exp     = ref_div(sgn, a, b);
    exp_lat = (b == 32'd0) ? 1 : 33;
    @(negedge clk);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    bus.annul_i      = 1'b0;
    @(posedge clk);
    #1;
    bus.opdata1_i    = $urandom;
    bus.opdata2_i    = $urandom;
    bus.signed_div_i = 1'($urandom_range(0, 1));
    wait_ready(60, lat);
    got = bus.result_o;
    check_eq("latency", 64'(lat), 64'(exp_lat));
    check_eq("result", bus.result_o, exp);
    @(posedge clk);
    @(negedge clk);
    check_eq("hold_ready", 64'(bus.ready_o), 64'd1);
    check_eq("hold_result", bus.result_o, exp);
    bus.start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("release_ready", 64'(bus.ready_o), 64'd0);
    check_eq("release_result", bus.result_o, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] got;
    logic        seen;
    int          lat;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;

    rst              = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd0;
    bus.opdata2_i    = 32'd0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_ready", 64'(bus.ready_o), 64'd0);
    check_eq("reset_result", bus.result_o, 64'd0);
    rst = 1'b1;

    run_op(1'b0, 32'd100, 32'd7, got);
    check_eq("divu_100_7", got, 64'h00000002_0000000E);
    run_op(1'b1, 32'hFFFFFFF9, 32'h2, got);
    check_eq("div_m7_2", got, 64'hFFFFFFFF_FFFFFFFD);
    run_op(1'b1, 32'h7, 32'hFFFFFFFE, got);
    check_eq("div_7_m2", got, 64'h00000001_FFFFFFFD);
    run_op(1'b1, 32'd5, 32'd0, got);
    run_op(1'b0, 32'd5, 32'd0, got);
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, got);
    check_eq("div_overflow", got, 64'h00000000_80000000);
    run_op(1'b0, 32'hFFFFFFFF, 32'd1, got);
    check_eq("divu_max_1", got, 64'h00000000_FFFFFFFF);

    // Annul in the tenth ON cycle must abandon the operation.
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen = seen | bus.ready_o;
    end
    check_eq("annul_no_ready", 64'(seen), 64'd0);
    run_op(1'b0, 32'hFFFFFFFF, 32'h10, got);
    check_eq("after_annul", got, 64'h0000000F_0FFFFFFF);

    // Asynchronous reset between edges, mid-ON and while a result is held.
    @(negedge clk);
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    bus.start_i   = 1'b1;
    @(posedge clk);
    repeat (15) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("rst_on_ready", 64'(bus.ready_o), 64'd0);
    check_eq("rst_on_result", bus.result_o, 64'd0);
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_op(1'b0, 32'd100, 32'd7, got);
    check_eq("after_rst", got, 64'h00000002_0000000E);

    @(negedge clk);
    bus.signed_div_i = 1'b1;
    bus.opdata1_i    = 32'hFFFFFF9C;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    @(posedge clk);
    wait_ready(60, lat);
    check_eq("end_result", bus.result_o, 64'hFFFFFFFE_FFFFFFF2);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("rst_end_ready", 64'(bus.ready_o), 64'd0);
    check_eq("rst_end_result", bus.result_o, 64'd0);
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    for (int n = 0; n < 30; n++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = ($urandom_range(0, 7) == 0) ? 32'h80000000 : 32'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 16));
        2:       b = 32'($urandom);
        3:       b = 32'd0 - 32'($urandom_range(1, 5));
        default: b = 32'd1;
      endcase
      run_op(sgn, a, b, got);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
